// File: rtl/keypad_matrix_scan_pkg.sv
// Shared definitions for the 4x4 keypad scanner: matrix size, FSM state
// encoding and the frame-result convention (valid bit alongside a 4-bit code).
package keypad_matrix_scan_pkg;

   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 4;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2,
      ST_RELEASE  = 2'd3
   } kp_state_t;

   // A frame result of "no key" is hit=0; code is then don't-care (driven 0).
   typedef struct packed {
      logic       hit;
      logic [3:0] code;
   } frame_result_t;

   // Key code is row-major: row*4 + col.
   function automatic logic [3:0] make_code(input logic [1:0] row, input logic [1:0] col);
      return {row, col};
   endfunction

endpackage

// File: rtl/keypad_frame_sampler.sv
// Row strobing and per-frame priority encoding. One row is driven low per
// tick; the first closed switch in row-major order wins for the frame.
// The frame result is presented combinationally on the tick that samples the
// last row, so the debounce FSM updates on that same edge.
module keypad_frame_sampler
   import keypad_matrix_scan_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic [3:0] col_in,
   output logic [3:0] n_row,
   output logic       frame_done,
   output logic       frame_hit,
   output logic [3:0] frame_code
);

   localparam logic [1:0] LAST_ROW = 2'(NUM_ROWS - 1);

   logic [1:0] row_reg;
   logic [1:0] row_next;
   logic [3:0] n_row_reg;
   logic       hit_reg;
   logic [3:0] code_reg;
   logic       row_hit;
   logic [1:0] row_col;

   // Lowest-numbered closed column on the currently driven row (col_in is active-low).
   always_comb begin
      row_hit = 1'b0;
      row_col = 2'd0;
      for (int c = NUM_COLS - 1; c >= 0; c--) begin
         if (!col_in[c]) begin
            row_hit = 1'b1;
            row_col = c[1:0];
         end
      end
   end

   assign row_next   = row_reg + 2'd1;
   assign frame_done = tick && (row_reg == LAST_ROW);
   // An earlier row in this frame always beats the row being sampled now.
   assign frame_hit  = hit_reg | row_hit;
   assign frame_code = hit_reg ? code_reg : (row_hit ? make_code(row_reg, row_col) : 4'd0);
   assign n_row      = n_row_reg;

   // Advance the row on each tick and accumulate the first hit of the frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_reg   <= 2'd0;
         n_row_reg <= 4'b1110;
         hit_reg   <= 1'b0;
         code_reg  <= 4'd0;
      end else if (tick) begin
         row_reg   <= row_next;
         n_row_reg <= ~(4'b0001 << row_next);
         if (row_reg == LAST_ROW) begin
            hit_reg  <= 1'b0;
            code_reg <= 4'd0;
         end else if (!hit_reg && row_hit) begin
            hit_reg  <= 1'b1;
            code_reg <= make_code(row_reg, row_col);
         end
      end
   end

endmodule

// File: rtl/keypad_matrix_scan.sv
// 4x4 keypad scanner top: frame sampler plus a frame-rate debounce FSM that
// reports each accepted press once (key_code + one-cycle key_valid) and
// holds key_down through the release debounce.
module keypad_matrix_scan
   import keypad_matrix_scan_pkg::*;
#(
   parameter int DEBOUNCE_FRAMES = 4
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic [3:0] col_in,
   output logic [3:0] n_row,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_down
);

   localparam logic [3:0] DF     = 4'(DEBOUNCE_FRAMES);
   localparam bit         SINGLE = (DEBOUNCE_FRAMES == 1);

   logic       frame_done;
   logic       frame_hit;
   logic [3:0] frame_code;

   kp_state_t  state_reg;
   logic [3:0] cnt_reg;
   logic [3:0] cnt_inc;
   logic [3:0] cand_reg;
   logic [3:0] key_code_reg;
   logic       key_valid_reg;
   logic       key_down_reg;

   keypad_frame_sampler u_sampler (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .col_in     (col_in),
      .n_row      (n_row),
      .frame_done (frame_done),
      .frame_hit  (frame_hit),
      .frame_code (frame_code)
   );

   assign cnt_inc = cnt_reg + 4'd1;

   // Debounce FSM, stepped once per completed frame; outputs are registered here too.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= 4'd0;
         cand_reg      <= 4'd0;
         key_code_reg  <= 4'd0;
         key_valid_reg <= 1'b0;
         key_down_reg  <= 1'b0;
      end else begin
         key_valid_reg <= 1'b0;
         if (frame_done) begin
            case (state_reg)
               ST_IDLE: begin
                  if (frame_hit) begin
                     cand_reg <= frame_code;
                     if (SINGLE) begin
                        state_reg     <= ST_HELD;
                        cnt_reg       <= 4'd0;
                        key_code_reg  <= frame_code;
                        key_valid_reg <= 1'b1;
                        key_down_reg  <= 1'b1;
                     end else begin
                        state_reg <= ST_DEBOUNCE;
                        cnt_reg   <= 4'd1;
                     end
                  end
               end
               ST_DEBOUNCE: begin
                  if (!frame_hit) begin
                     state_reg <= ST_IDLE;
                     cnt_reg   <= 4'd0;
                  end else if (frame_code == cand_reg) begin
                     cnt_reg <= cnt_inc;
                     if (cnt_inc == DF) begin
                        state_reg     <= ST_HELD;
                        key_code_reg  <= cand_reg;
                        key_valid_reg <= 1'b1;
                        key_down_reg  <= 1'b1;
                     end
                  end else begin
                     // Key changed while bouncing: restart on the new candidate.
                     cand_reg <= frame_code;
                     cnt_reg  <= 4'd1;
                  end
               end
               ST_HELD: begin
                  // Any key keeps us here; a new press needs a full release first.
                  if (!frame_hit) begin
                     if (SINGLE) begin
                        state_reg    <= ST_IDLE;
                        cnt_reg      <= 4'd0;
                        key_down_reg <= 1'b0;
                     end else begin
                        state_reg <= ST_RELEASE;
                        cnt_reg   <= 4'd1;
                     end
                  end
               end
               ST_RELEASE: begin
                  if (frame_hit) begin
                     state_reg <= ST_HELD;
                  end else begin
                     cnt_reg <= cnt_inc;
                     if (cnt_inc == DF) begin
                        state_reg    <= ST_IDLE;
                        key_down_reg <= 1'b0;
                     end
                  end
               end
               default: begin
                  state_reg    <= ST_IDLE;
                  cnt_reg      <= 4'd0;
                  key_down_reg <= 1'b0;
               end
            endcase
         end
      end
   end

   assign key_code  = key_code_reg;
   assign key_valid = key_valid_reg;
   assign key_down  = key_down_reg;

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// Directed bench for keypad_matrix_scan with a behavioural key matrix:
// col_in is derived from the driven row and the set of closed keys.
module tb_keypad_matrix_scan;

   logic       clk;
   logic       rst;
   logic       tick;
   logic [3:0] col_in;
   logic [3:0] n_row;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_down;

   logic [15:0] keys;   // bit k set = key with code k closed

   int vectors;
   int miscompares;

   keypad_matrix_scan #(.DEBOUNCE_FRAMES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .col_in    (col_in),
      .n_row     (n_row),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_down  (key_down)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Passive matrix: a closed key pulls its column low while its row is driven low.
   always_comb begin
      col_in = 4'hF;
      for (int r = 0; r < 4; r++) begin
         if (!n_row[r]) begin
            for (int c = 0; c < 4; c++) begin
               if (keys[r*4+c]) col_in[c] = 1'b0;
            end
         end
      end
   end

   task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s = %0h", tag, obs);
      end
   endtask

   // Run n clock edges with tick high; count key_valid pulses and edges with key_down low.
   task automatic run_edges(input int n, output int pulses, output int down_low);
      pulses   = 0;
      down_low = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (key_valid) pulses++;
         if (!key_down) down_low++;
      end
   endtask

   task automatic run_frames(input int n, output int pulses, output int down_low);
      run_edges(4 * n, pulses, down_low);
   endtask

   initial begin
      int          p;
      int          dl;
      int          bad;
      logic [3:0]  exp_row;
      logic [3:0]  one;

      vectors     = 0;
      miscompares = 0;
      one         = 4'b0001;
      rst         = 1'b1;
      tick        = 1'b1;
      keys        = 16'h0200;   // key 9 (row2,col1) closed from reset

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_n_row", 16'(n_row), 16'h000E);
      check_val("rst_key_code", 16'(key_code), 16'h0);
      check_val("rst_key_valid", 16'(key_valid), 16'h0);
      check_val("rst_key_down", 16'(key_down), 16'h0);
      rst = 1'b0;

      // Press of key 9 from reset: accepted on tick edge 16
      for (int i = 1; i <= 16; i++) begin
         @(posedge clk);
         #1;
         exp_row = ~(one << (i % 4));
         check_val($sformatf("scan_n_row_e%0d", i), 16'(n_row), 16'(exp_row));
         check_val($sformatf("scan_valid_e%0d", i), 16'(key_valid), (i == 16) ? 16'h1 : 16'h0);
      end
      check_val("scan_code", 16'(key_code), 16'd9);
      check_val("scan_down", 16'(key_down), 16'h1);

      // Release glitch: 2 empty frames, then the key returns
      keys = 16'h0000;
      run_frames(2, p, dl);
      check_val("glitch_pulses_a", 16'(p), 16'd0);
      check_val("glitch_down_a", 16'(dl), 16'd0);
      keys = 16'h0200;
      run_frames(2, p, dl);
      check_val("glitch_pulses_b", 16'(p), 16'd0);
      check_val("glitch_down_b", 16'(dl), 16'd0);
      check_val("glitch_code", 16'(key_code), 16'd9);

      // Full release
      keys = 16'h0000;
      run_frames(3, p, dl);
      check_val("rel3_down", 16'(key_down), 16'h1);
      run_frames(1, p, dl);
      check_val("rel4_down", 16'(key_down), 16'h0);
      check_val("rel_code_hold", 16'(key_code), 16'd9);

      // Bounce: key 3 open on frame 3 of debounce, then a stable press
      keys = 16'h0008;
      run_frames(2, p, dl);
      keys = 16'h0000;
      run_frames(1, p, dl);
      keys = 16'h0008;
      run_frames(3, p, dl);
      check_val("bounce_no_pulse", 16'(p), 16'd0);
      check_val("bounce_down", 16'(key_down), 16'h0);
      run_frames(1, p, dl);
      check_val("bounce_pulse", 16'(p), 16'd1);
      check_val("bounce_code", 16'(key_code), 16'd3);
      keys = 16'h0000;
      run_frames(4, p, dl);
      check_val("bounce_rel", 16'(key_down), 16'h0);

      // Two keys: 5 and 14 together -> 5 wins
      keys = 16'h4020;
      run_frames(4, p, dl);
      check_val("dual_pulse", 16'(p), 16'd1);
      check_val("dual_code", 16'(key_code), 16'd5);
      keys = 16'h4000;
      run_frames(4, p, dl);
      check_val("dual_keep_pulse", 16'(p), 16'd0);
      check_val("dual_keep_code", 16'(key_code), 16'd5);
      check_val("dual_keep_down", 16'(dl), 16'd0);
      keys = 16'h0000;
      run_frames(4, p, dl);
      check_val("dual_rel_down", 16'(key_down), 16'h0);
      keys = 16'h4000;
      run_frames(4, p, dl);
      check_val("k14_pulse", 16'(p), 16'd1);
      check_val("k14_code", 16'(key_code), 16'd14);
      keys = 16'h0000;
      run_frames(4, p, dl);

      // Reset mid-frame during debounce of key 6
      keys = 16'h0040;
      run_frames(2, p, dl);
      run_edges(2, p, dl);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_val("mid_rst_n_row", 16'(n_row), 16'h000E);
      check_val("mid_rst_code", 16'(key_code), 16'h0);
      check_val("mid_rst_valid", 16'(key_valid), 16'h0);
      check_val("mid_rst_down", 16'(key_down), 16'h0);
      rst = 1'b0;
      run_frames(3, p, dl);
      check_val("mid_rst_no_early", 16'(p), 16'd0);
      run_frames(1, p, dl);
      check_val("mid_rst_pulse", 16'(p), 16'd1);
      check_val("mid_rst_code6", 16'(key_code), 16'd6);

      // Tick gated low for 100 cycles: nothing may move
      run_edges(2, p, dl);
      check_val("gate_start_row", 16'(n_row), 16'h000B);
      tick = 1'b0;
      keys = 16'h0000;
      bad  = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         if (n_row !== 4'b1011 || key_down !== 1'b1 || key_valid !== 1'b0 || key_code !== 4'd6)
            bad++;
      end
      check_val("gate_stable", 16'(bad), 16'd0);
      tick = 1'b1;
      run_frames(1, p, dl);
      check_val("gate_resume_down", 16'(key_down), 16'h1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
